// File: rtl/mac_pkg.sv
// mac_lane shared types and constants.
// State encoding and FIFO sizing for the MAC lane.
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        EMIT
    } state_t;

    localparam int FIFO_DEPTH    = 4;
    localparam int FIFO_LOG      = 2;
    localparam int DEF_ACC_WIDTH = 32;

endpackage

// File: rtl/mac_lane_if.sv
// mac_lane port bundle.
// Config, activation/weight streams and result handshake.
interface mac_lane_if
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH             = 8,
    parameter int ACC_WIDTH              = DEF_ACC_WIDTH,
    parameter int LOG_MAX_ITERS          = 16,
    parameter int LOG_MAX_READS_PER_ITER = 16
);
    logic                              configure;
    logic [LOG_MAX_ITERS-1:0]          num_iters;
    logic [LOG_MAX_READS_PER_ITER-1:0] num_reads_per_iter;
    logic [DATA_WIDTH-1:0]             act_data_in;
    logic                              act_valid_in;
    logic                              act_avail_out;
    logic [DATA_WIDTH-1:0]             weight_data_in;
    logic                              weight_valid_in;
    logic                              weight_avail_out;
    logic [ACC_WIDTH-1:0]              data_out;
    logic                              valid_out;
    logic                              avail_in;
    logic                              busy_out;

    modport master (
        output configure, num_iters, num_reads_per_iter,
        output act_data_in, act_valid_in,
        output weight_data_in, weight_valid_in, avail_in,
        input  act_avail_out, weight_avail_out,
        input  data_out, valid_out, busy_out
    );

    modport slave (
        input  configure, num_iters, num_reads_per_iter,
        input  act_data_in, act_valid_in,
        input  weight_data_in, weight_valid_in, avail_in,
        output act_avail_out, weight_avail_out,
        output data_out, valid_out, busy_out
    );

endinterface

// File: rtl/mac_lane_fifo.sv
// Small input FIFO with one slot of slack.
// avail drops one entry before full so a late sender still fits.
module mac_lane_fifo
    import mac_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             avail
);
    localparam logic [FIFO_LOG:0] FULL_CNT = (FIFO_LOG+1)'(FIFO_DEPTH);

    logic [WIDTH-1:0]    mem [FIFO_DEPTH];
    logic [FIFO_LOG-1:0] wr_ptr;
    logic [FIFO_LOG-1:0] rd_ptr;
    logic [FIFO_LOG:0]   cnt;
    logic                up_r;
    logic                full;
    logic                almost_full;
    logic                do_wr;
    logic                do_rd;

    assign full        = (cnt == FULL_CNT);
    assign almost_full = (cnt == FULL_CNT - (FIFO_LOG+1)'(1));
    assign empty       = (cnt == '0);
    assign do_rd       = rd_en & ~empty;
    assign do_wr       = wr_en & (~full | do_rd);
    assign rd_data     = mem[rd_ptr];
    assign avail       = up_r & ~almost_full & ~full;

    // Storage array; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and post-reset availability.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            up_r   <= 1'b0;
        end else begin
            up_r <= 1'b1;
            if (do_wr) begin
                wr_ptr <= wr_ptr + FIFO_LOG'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + FIFO_LOG'(1);
            end
            cnt <= cnt + (FIFO_LOG+1)'(do_wr) - (FIFO_LOG+1)'(do_rd);
        end
    end

endmodule

// File: rtl/mac_lane.sv
// Per-lane multiply-accumulate stage.
// Sums reads-per-iter act*weight products, one result per iteration.
module mac_lane
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH             = 8,
    parameter int ACC_WIDTH              = DEF_ACC_WIDTH,
    parameter int LOG_MAX_ITERS          = 16,
    parameter int LOG_MAX_READS_PER_ITER = 16
) (
    input logic       clk,
    input logic       rst,
    mac_lane_if.slave bus
);
    localparam int DW = DATA_WIDTH;
    localparam int AW = ACC_WIDTH;
    localparam int PW = 2 * DATA_WIDTH;
    localparam int LI = LOG_MAX_ITERS;
    localparam int LR = LOG_MAX_READS_PER_ITER;

    state_t               state;
    state_t               state_nx;
    logic [LI-1:0]        iters_r;
    logic [LR-1:0]        reads_r;
    logic [LR-1:0]        reads_copy_r;
    logic signed [DW-1:0] weight_r;
    logic signed [DW-1:0] act_q;
    logic signed [DW-1:0] wt_q;
    logic signed [DW-1:0] w_use;
    logic                 act_empty;
    logic                 wt_empty;
    logic                 act_avail;
    logic                 wt_avail;
    logic                 first_read;
    logic                 last_read;
    logic                 cfg_ok;
    logic                 op;
    logic                 wt_pop;
    logic                 emit_done;
    logic signed [PW-1:0] prod_r;
    logic                 first_s1;
    logic                 v1;
    logic [AW-1:0]        acc_r;
    logic [AW-1:0]        result_r;

    mac_lane_fifo #(.WIDTH(DW)) u_act_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (bus.act_valid_in),
        .wr_data (bus.act_data_in),
        .rd_en   (op),
        .rd_data (act_q),
        .empty   (act_empty),
        .avail   (act_avail)
    );

    mac_lane_fifo #(.WIDTH(DW)) u_wt_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (bus.weight_valid_in),
        .wr_data (bus.weight_data_in),
        .rd_en   (wt_pop),
        .rd_data (wt_q),
        .empty   (wt_empty),
        .avail   (wt_avail)
    );

    assign first_read = (reads_r == reads_copy_r);
    assign last_read  = (reads_r == LR'(1));
    assign cfg_ok     = bus.configure & (|bus.num_iters)
                      & (|bus.num_reads_per_iter);
    assign wt_pop     = op & first_read;
    assign w_use      = first_read ? wt_q : weight_r;

    assign bus.act_avail_out    = act_avail;
    assign bus.weight_avail_out = wt_avail;
    assign bus.data_out         = result_r;
    assign bus.valid_out        = emit_done;
    assign bus.busy_out         = (state != IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state, op issue and result handshake.
    always_comb begin
        state_nx  = state;
        op        = 1'b0;
        emit_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (cfg_ok) state_nx = RUN;
            end
            RUN: begin
                op = ~act_empty & (~first_read | ~wt_empty);
                if (op && last_read) state_nx = FLUSH;
            end
            FLUSH: begin
                if (!v1) state_nx = EMIT;
            end
            EMIT: begin
                emit_done = bus.avail_in;
                if (emit_done) begin
                    state_nx = (iters_r == LI'(1)) ? IDLE : RUN;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Iteration/read counters and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            iters_r      <= '0;
            reads_r      <= '0;
            reads_copy_r <= '0;
            result_r     <= '0;
        end else begin
            if (state == IDLE && cfg_ok) begin
                iters_r      <= bus.num_iters;
                reads_r      <= bus.num_reads_per_iter;
                reads_copy_r <= bus.num_reads_per_iter;
            end
            if (op) begin
                reads_r <= last_read ? reads_copy_r : reads_r - LR'(1);
            end
            if (state == FLUSH && !v1) begin
                result_r <= acc_r;
            end
            if (emit_done && iters_r != LI'(1)) begin
                iters_r <= iters_r - LI'(1);
            end
        end
    end

    // Two-stage multiply then accumulate, wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1       <= 1'b0;
            first_s1 <= 1'b0;
            prod_r   <= '0;
            weight_r <= '0;
            acc_r    <= '0;
        end else begin
            v1 <= op;
            if (op) begin
                prod_r   <= PW'(act_q) * PW'(w_use);
                first_s1 <= first_read;
            end
            if (wt_pop) begin
                weight_r <= wt_q;
            end
            if (v1) begin
                acc_r <= (first_s1 ? {AW{1'b0}} : acc_r) + AW'(prod_r);
            end
        end
    end

endmodule

// File: tb/tb_mac_lane.sv
// Self-checking bench for mac_lane.
// Table vectors, directed corner sequences and randomized jobs.
module tb_mac_lane;
    localparam int DW = 8;
    localparam int AW = 16;
    localparam int LI = 16;
    localparam int LR = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mac_lane_if #(
        .DATA_WIDTH(DW), .ACC_WIDTH(AW),
        .LOG_MAX_ITERS(LI), .LOG_MAX_READS_PER_ITER(LR)
    ) bus ();

    mac_lane #(
        .DATA_WIDTH(DW), .ACC_WIDTH(AW),
        .LOG_MAX_ITERS(LI), .LOG_MAX_READS_PER_ITER(LR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int iters;
        int reads;
        int w [4];
        int a [16];
        int e [4];
    } vec_t;

    vec_t tbl [5];
    int   checks = 0;
    int   errors = 0;
    int   viol   = 0;
    int   aq [$];
    int   wq [$];
    int   eq [$];

    // Sender must never write into a FIFO that has dropped avail.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(bus.act_valid_in && !bus.act_avail_out)) else viol++;
            assert (!(bus.weight_valid_in && !bus.weight_avail_out)) else viol++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic cfg(input int it, input int rd, input logic exp_busy);
        bus.configure          = 1'b1;
        bus.num_iters          = LI'(it);
        bus.num_reads_per_iter = LR'(rd);
        @(negedge clk);
        bus.configure = 1'b0;
        chk("cfg_busy", 32'(bus.busy_out), 32'(exp_busy));
    endtask

    task automatic feed_a(input bit rnd);
        int g = 0;
        while (aq.size() > 0 && g < 1000) begin
            if (bus.act_avail_out && (!rnd || $urandom_range(3) != 0)) begin
                bus.act_data_in  = DW'(aq.pop_front());
                bus.act_valid_in = 1'b1;
            end else begin
                bus.act_valid_in = 1'b0;
            end
            @(negedge clk);
            g++;
        end
        bus.act_valid_in = 1'b0;
        chk("act_feed_left", aq.size(), 0);
    endtask

    task automatic feed_w(input bit rnd);
        int g = 0;
        while (wq.size() > 0 && g < 1000) begin
            if (bus.weight_avail_out && (!rnd || $urandom_range(3) != 0)) begin
                bus.weight_data_in  = DW'(wq.pop_front());
                bus.weight_valid_in = 1'b1;
            end else begin
                bus.weight_valid_in = 1'b0;
            end
            @(negedge clk);
            g++;
        end
        bus.weight_valid_in = 1'b0;
        chk("wt_feed_left", wq.size(), 0);
    endtask

    task automatic collect(input bit rnd);
        int g = 0;
        while (eq.size() > 0 && g < 1000) begin
            bus.avail_in = rnd ? ($urandom_range(2) != 0) : 1'b1;
            #1;
            if (bus.valid_out) begin
                logic [AW-1:0] ev;
                ev = AW'(eq.pop_front());
                chk("result", 32'(bus.data_out), 32'(ev));
            end
            @(negedge clk);
            g++;
        end
        chk("results_left", eq.size(), 0);
    endtask

    task automatic run_job(input int it, input int rd, input bit rnd);
        cfg(it, rd, 1'b1);
        fork
            feed_w(rnd);
            feed_a(rnd);
            collect(rnd);
        join
        bus.avail_in = 1'b1;
        @(negedge clk);
        chk("job_busy_end", 32'(bus.busy_out), 0);
        chk("job_valid_end", 32'(bus.valid_out), 0);
    endtask

    initial begin
        tbl[0] = '{1, 4, '{3, 0, 0, 0},
                   '{1, 2, 3, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
                   '{30, 0, 0, 0}};
        tbl[1] = '{2, 2, '{-2, 5, 0, 0},
                   '{7, -1, 4, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
                   '{-12, 40, 0, 0}};
        tbl[2] = '{1, 4, '{-128, 0, 0, 0},
                   '{-128, -128, -128, -128, 0, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 0},
                   '{0, 0, 0, 0}};
        tbl[3] = '{3, 1, '{2, -3, 4, 0},
                   '{5, 6, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
                   '{10, -18, 28, 0}};
        tbl[4] = '{1, 3, '{127, 0, 0, 0},
                   '{127, 127, 127, 0, 0, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 0},
                   '{48387, 0, 0, 0}};

        bus.configure          = 1'b0;
        bus.num_iters          = '0;
        bus.num_reads_per_iter = '0;
        bus.act_data_in        = '0;
        bus.act_valid_in       = 1'b0;
        bus.weight_data_in     = '0;
        bus.weight_valid_in    = 1'b0;
        bus.avail_in           = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(bus.valid_out), 0);
        chk("rst_busy", 32'(bus.busy_out), 0);
        chk("rst_data", 32'(bus.data_out), 0);
        chk("rst_aavail", 32'(bus.act_avail_out), 0);
        chk("rst_wavail", 32'(bus.weight_avail_out), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_aavail", 32'(bus.act_avail_out), 1);
        chk("post_rst_wavail", 32'(bus.weight_avail_out), 1);

        // Latency: last pop to valid_out is three cycles
        bus.weight_data_in  = DW'(3);
        bus.weight_valid_in = 1'b1;
        bus.act_data_in     = DW'(1);
        bus.act_valid_in    = 1'b1;
        @(negedge clk);
        bus.weight_valid_in = 1'b0;
        bus.act_data_in     = DW'(2);
        @(negedge clk);
        bus.act_data_in        = DW'(3);
        bus.configure          = 1'b1;
        bus.num_iters          = LI'(1);
        bus.num_reads_per_iter = LR'(4);
        @(negedge clk);
        bus.act_valid_in = 1'b0;
        bus.configure    = 1'b0;
        chk("lat_aavail_low", 32'(bus.act_avail_out), 0);
        chk("lat_busy", 32'(bus.busy_out), 1);
        @(negedge clk);
        chk("lat_aavail_high", 32'(bus.act_avail_out), 1);
        bus.act_data_in  = DW'(4);
        bus.act_valid_in = 1'b1;
        @(negedge clk);
        bus.act_valid_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("lat_valid_t1", 32'(bus.valid_out), 0);
        @(negedge clk);
        chk("lat_valid_t2", 32'(bus.valid_out), 0);
        @(negedge clk);
        chk("lat_valid_t3", 32'(bus.valid_out), 1);
        chk("lat_data", 32'(bus.data_out), 30);
        chk("lat_busy_hold", 32'(bus.busy_out), 1);
        @(negedge clk);
        chk("lat_busy_fall", 32'(bus.busy_out), 0);
        chk("lat_valid_off", 32'(bus.valid_out), 0);

        // Table vectors
        for (int k = 0; k < 5; k++) begin
            aq.delete();
            wq.delete();
            eq.delete();
            for (int it = 0; it < tbl[k].iters; it++) begin
                wq.push_back(tbl[k].w[it]);
                eq.push_back(tbl[k].e[it]);
            end
            for (int r = 0; r < tbl[k].iters * tbl[k].reads; r++) begin
                aq.push_back(tbl[k].a[r]);
            end
            run_job(tbl[k].iters, tbl[k].reads, 1'b0);
        end

        // Zero-valued configures ignored; configure during RUN ignored
        bus.weight_data_in  = DW'(4);
        bus.weight_valid_in = 1'b1;
        bus.act_data_in     = DW'(1);
        bus.act_valid_in    = 1'b1;
        @(negedge clk);
        bus.weight_valid_in = 1'b0;
        bus.act_data_in     = DW'(2);
        @(negedge clk);
        bus.act_data_in = DW'(3);
        @(negedge clk);
        bus.act_valid_in = 1'b0;
        chk("idle_aavail_full", 32'(bus.act_avail_out), 0);
        cfg(2, 0, 1'b0);
        cfg(0, 3, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("bad_cfg_no_pop", 32'(bus.act_avail_out), 0);
        chk("bad_cfg_busy", 32'(bus.busy_out), 0);
        cfg(1, 3, 1'b1);
        cfg(5, 1, 1'b1);
        eq.push_back(24);
        collect(1'b0);
        @(negedge clk);
        chk("run_cfg_busy_end", 32'(bus.busy_out), 0);
        @(negedge clk);
        chk("run_cfg_idle", 32'(bus.busy_out), 0);
        chk("run_cfg_no_valid", 32'(bus.valid_out), 0);

        // Result stall in EMIT while activations keep arriving
        bus.avail_in        = 1'b0;
        bus.weight_data_in  = DW'(2);
        bus.weight_valid_in = 1'b1;
        bus.act_data_in     = DW'(1);
        bus.act_valid_in    = 1'b1;
        @(negedge clk);
        bus.weight_data_in = DW'(-1);
        bus.act_data_in    = DW'(2);
        @(negedge clk);
        bus.weight_valid_in = 1'b0;
        bus.act_data_in     = DW'(3);
        @(negedge clk);
        bus.act_valid_in = 1'b0;
        cfg(2, 3, 1'b1);
        repeat (8) @(negedge clk);
        begin
            int bw;
            bw = 0;
            for (int k = 0; k < 10; k++) begin
                chk("stall_valid", 32'(bus.valid_out), 0);
                chk("stall_data", 32'(bus.data_out), 12);
                if (k == 3) begin
                    chk("stall_aavail", 32'(bus.act_avail_out), 0);
                end
                if (bw < 3 && bus.act_avail_out) begin
                    bus.act_data_in  = DW'(bw + 4);
                    bus.act_valid_in = 1'b1;
                    bw++;
                end else begin
                    bus.act_valid_in = 1'b0;
                end
                @(negedge clk);
            end
        end
        bus.avail_in = 1'b1;
        #1;
        chk("stall_release_valid", 32'(bus.valid_out), 1);
        chk("stall_release_data", 32'(bus.data_out), 12);
        @(negedge clk);
        eq.push_back(-15);
        collect(1'b0);
        @(negedge clk);
        chk("stall_busy_end", 32'(bus.busy_out), 0);

        // Reset mid-RUN after two of four ops
        bus.weight_data_in  = DW'(3);
        bus.weight_valid_in = 1'b1;
        bus.act_data_in     = DW'(1);
        bus.act_valid_in    = 1'b1;
        @(negedge clk);
        bus.weight_data_in = DW'(7);
        bus.act_data_in    = DW'(2);
        @(negedge clk);
        bus.weight_valid_in = 1'b0;
        bus.act_data_in     = DW'(3);
        @(negedge clk);
        bus.act_valid_in = 1'b0;
        cfg(1, 4, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", 32'(bus.valid_out), 0);
        chk("mid_rst_data", 32'(bus.data_out), 0);
        chk("mid_rst_busy", 32'(bus.busy_out), 0);
        chk("mid_rst_aavail", 32'(bus.act_avail_out), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_aavail_up", 32'(bus.act_avail_out), 1);
        chk("mid_rst_wavail_up", 32'(bus.weight_avail_out), 1);
        wq.push_back(-4);
        aq.push_back(2);
        aq.push_back(3);
        eq.push_back(-20);
        run_job(1, 2, 1'b0);

        // Randomized jobs against the arithmetic model
        for (int j = 0; j < 30; j++) begin
            int it;
            int rd;
            it = int'($urandom_range(4, 1));
            rd = int'($urandom_range(6, 1));
            for (int n = 0; n < it; n++) begin
                int w;
                int s;
                w = int'($urandom_range(255)) - 128;
                s = 0;
                wq.push_back(w);
                for (int r = 0; r < rd; r++) begin
                    int a;
                    a = int'($urandom_range(255)) - 128;
                    aq.push_back(a);
                    s += a * w;
                end
                eq.push_back(s);
            end
            run_job(it, rd, 1'b1);
        end

        chk("protocol_violations", viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
